// File: rtl/divider_iter_32_pkg.sv
// Shared definitions for the iterative radix-2 divider used beside the EX-stage multiplier.
package divider_iter_32_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;
    localparam logic [DIV_WIDTH-1:0] SIGNED_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/divider_iter_32_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor on entry, so the shifted partial remainder always fits in WIDTH+1 bits.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider_iter_32.sv
// Sequential restoring divider for RV32M DIV/DIVU/REM/REMU with a start/busy/done handshake.
module divider_iter_32
    import divider_iter_32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_t             state;
    logic [DIV_CNT_W-1:0]   count;
    logic [WIDTH-1:0]       rem_r;
    logic [WIDTH-1:0]       quo_r;
    logic [WIDTH-1:0]       dvsr_r;
    logic                   neg_q;
    logic                   neg_r;

    logic                   a_neg;
    logic                   b_neg;
    logic [WIDTH-1:0]       a_abs;
    logic [WIDTH-1:0]       b_abs;
    logic [WIDTH-1:0]       step_rem;
    logic [WIDTH-1:0]       step_quo;

    always_comb begin
        a_neg = sign & src1[WIDTH-1];
        b_neg = sign & src2[WIDTH-1];
        a_abs = a_neg ? (~src1 + 1'b1) : src1;
        b_abs = b_neg ? (~src2 + 1'b1) : src2;
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvsr_r),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvsr_r    <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy   <= 1'b1;
                        neg_q  <= sign & (src1[WIDTH-1] ^ src2[WIDTH-1]);
                        neg_r  <= a_neg;
                        quo_r  <= a_abs;
                        rem_r  <= '0;
                        dvsr_r <= b_abs;
                        count  <= '0;
                        // Special cases bypass the iteration and report on the next cycle.
                        if (src2 == '0) begin
                            quotient  <= DIV_ZERO_Q;
                            remainder <= src1;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else if (sign && (src1 == SIGNED_MIN) && (src2 == '1)) begin
                            quotient  <= SIGNED_MIN;
                            remainder <= '0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_r <= step_rem;
                    quo_r <= step_quo;
                    count <= count + 1'b1;
                    if (count == DIV_CNT_W'(ITERS - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= neg_q ? (~quo_r + 1'b1) : quo_r;
                    remainder <= neg_r ? (~rem_r + 1'b1) : rem_r;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_iter_32.sv
// Scoreboard bench for divider_iter_32: expected results queued at issue, checked on each done pulse.
module tb_divider_iter_32;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_fail;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int unsigned due;
        string       tag;
    } exp_t;

    exp_t sb[$];

    divider_iter_32 #(
        .WIDTH(32),
        .ITERS(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sign      (sign),
        .src1      (src1),
        .src2      (src2),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint q;
        longint r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
        if (s) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
        end
        return {q[31:0], r[31:0]};
    endfunction

    // Drive one start cycle and queue the expected result; returns at the negedge of T+1.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
        exp_t        e;
        logic [63:0] m;
        @(negedge clk);
        m     = model(s, a, b);
        e.q   = m[63:32];
        e.r   = m[31:0];
        e.tag = tag;
        e.due = cyc + (((b == 32'd0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34);
        sb.push_back(e);
        start = 1'b1;
        sign  = s;
        src1  = a;
        src2  = b;
        @(negedge clk);
        start = 1'b0;
        src1  = $urandom;
        src2  = $urandom;
        sign  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input string tag);
        int unsigned n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) check_value({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check_value("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_value({e.tag, "_q"}, quotient, e.q);
                check_value({e.tag, "_r"}, remainder, e.r);
                check_value({e.tag, "_lat"}, cyc, e.due);
                check_value({e.tag, "_busy"}, busy, 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b0;
        sign  = 1'b0;
        src1  = '0;
        src2  = '0;
        repeat (3) @(negedge clk);
        check_value("rst_busy", busy, 0);
        check_value("rst_done", done, 0);
        check_value("rst_q", quotient, 0);
        check_value("rst_r", remainder, 0);
        // Reset must win over a simultaneous start.
        start = 1'b1;
        src1  = 32'd9;
        src2  = 32'd3;
        @(negedge clk);
        check_value("rst_vs_start_busy", busy, 0);
        start = 1'b0;
        rst   = 1'b0;

        issue(1'b0, 32'd100, 32'd7, "udiv");
        check_value("busy_calc", busy, 1);
        wait_done("udiv");
        @(negedge clk);
        check_value("done_one_cycle", done, 0);
        check_value("busy_after", busy, 0);
        check_value("hold_q", quotient, 32'd14);

        issue(1'b1, 32'hFFFF_FFF9, 32'd2, "sneg_a");
        wait_done("sneg_a");
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, "sneg_b");
        wait_done("sneg_b");

        issue(1'b0, 32'h1234_5678, 32'd0, "dz_u");
        wait_done("dz_u");
        issue(1'b1, 32'h1234_5678, 32'd0, "dz_s");
        wait_done("dz_s");
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "ovf_s");
        wait_done("ovf_s");
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "ovf_u");
        wait_done("ovf_u");

        // Start during CALC must be ignored; then a back-to-back start right after done.
        issue(1'b0, 32'd1000, 32'd3, "hs1");
        repeat (3) @(negedge clk);
        start = 1'b1;
        sign  = 1'b1;
        src1  = 32'hDEAD_BEEF;
        src2  = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("hs1");
        issue(1'b1, 32'hFFFF_FF9C, 32'd7, "hs2");
        repeat (10) @(negedge clk);
        check_value("hold_hs1_q", quotient, 32'd333);
        check_value("hold_hs1_r", remainder, 32'd1);
        wait_done("hs2");

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            issue(1'(i % 2), a, b, "rand");
            wait_done("rand");
        end

        issue(1'b0, 32'd55, 32'd5, "rst_op");
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check_value("midrst_busy", busy, 0);
        check_value("midrst_done", done, 0);
        check_value("midrst_q", quotient, 0);
        check_value("midrst_r", remainder, 0);
        repeat (40) @(negedge clk);
        issue(1'b1, 32'd12345, 32'hFFFF_FFEF, "post_rst");
        wait_done("post_rst");

        repeat (3) @(negedge clk);
        check_value("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
